fifo_burst_reader: RTL
======================

// Module: fifo_burst_reader
// PURPOSE
//  Drain side of a register-based show-ahead sync FIFO. Pops words via empty/rd_en.
//  Presents them as a valid/ready stream framed into bursts of up to BURST_LEN beats, with m_last.
//  Partial bursts close on an idle timeout or on a flush request.
//  Sits between a sync FIFO's read port and a downstream packet/DMA consumer.
// PARAMETERS
//  DATA_WIDTH  8   word width; must equal the FIFO's DATA_WIDTH
//  BURST_LEN   16  max beats per burst, >=2
//  TIMEOUT     8   idle cycles before a held word closes a partial burst, >=1
// PORTS
//  clk         in   1                 clock; all logic on posedge
//  rst         in   1                 synchronous reset, active-high
//  fifo_data   in   DATA_WIDTH        FIFO head word; valid when !fifo_empty
//  fifo_empty  in   1                 FIFO empty flag
//  fifo_rd_en  out  1                 pop strobe to FIFO
//  flush       in   1                 close current burst now
//  m_data      out  DATA_WIDTH        stream data
//  m_valid     out  1                 stream valid
//  m_ready     in   1                 stream ready
//  m_last      out  1                 final beat of burst
//  m_beat      out  max(1,clog2(BL))  index of current beat within burst
//  busy        out  1                 hold register occupied
// BEHAVIOUR
//  Reset (rst=1 at posedge): all outputs 0 from the next cycle. fifo_rd_en=0 while rst=1.
//   Hold register, beat_cnt, to_cnt and pres all cleared; a held word is discarded.
//  Storage: one hold register H with hold_vld flag (busy = hold_vld).
//  Pop: fifo_rd_en = !rst && !fifo_empty && (!hold_vld || xfer), where xfer = m_valid && m_ready.
//   Never asserted while fifo_empty. Popped word is loaded into H at the same posedge.
//   H is loaded from the show-ahead head (fifo_data) in the pop cycle.
//  Lookahead: H is presented only once its framing is known. Presentation condition P, evaluated while hold_vld && !pres:
//   (a) beat_cnt==BURST_LEN-1         -> last=1
//   (b) !fifo_empty                   -> last = (beat_cnt==BURST_LEN-1)
//   (c) to_cnt==TIMEOUT or flush=1    -> last=1
//  Priority: (a) > (b) > (c).
//  When P holds: m_valid=1 in that same cycle (combinational); pres and last_lat register at the posedge.
//  pres/last_lat are sticky until xfer, so m_valid, m_data and m_last stay stable while m_ready=0,
//   even if the FIFO fills meanwhile.
//  to_cnt: cleared on H load; +1 per cycle while hold_vld && !P. Saturates at TIMEOUT.
//  Latency: a word written into an empty FIFO at cycle t shows !fifo_empty at t+1, is popped at t+1, and is in H at t+2.
//   A lone word gets m_valid at t+2+TIMEOUT.
//   Streaming at full rate with m_ready=1 gives 1 beat/cycle.
//  beat_cnt/m_beat: +1 on xfer; wraps to 0 on xfer with m_last=1. Never exceeds BURST_LEN-1.
//  Simultaneous xfer and pop: H reloads and pres clears in the same cycle; no bubble.
//  flush with !hold_vld: ignored. Flush does not abort a burst already presented.
// TESTING
//  BL=4,TO=8, write 0..7 back-to-back, m_ready=1 -> beats 0..7 in order, m_last on data 3 and 7, m_beat 0,1,2,3,0,1,2,3.
//  Single 0xA5 into empty FIFO -> m_valid exactly 8 cycles after H load, m_last=1, m_beat=0. Then busy=0.
//  Mid-burst m_ready=0 for 10 cycles with FIFO non-empty -> m_data/m_valid/m_last constant, fifo_rd_en=0, no loss or duplication.
//  Lone word presented by timeout (m_ready=0), then FIFO write 0x3C -> m_last stays 1. 0x3C follows with m_beat=0.
//  BL=16, 2 words in, FIFO empty, flush pulse on 2nd held word -> 2nd word presented next edge with m_last=1.
//  rst pulse mid-burst (H valid, pres=1) -> next cycle m_valid=0, busy=0, m_beat=0. fifo_rd_en=0 during rst. The following burst restarts at beat 0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drain side of a show-ahead sync FIFO: pops words into a single hold register and
// presents them as a valid/ready stream framed into bursts of up to BURST_LEN beats.

module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [DATA_WIDTH-1:0]                         fifo_data,
  input  logic                                          fifo_empty,
  output logic                                          fifo_rd_en,
  input  logic                                          flush,
  output logic [DATA_WIDTH-1:0]                         m_data,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic                                          m_last,
  output logic [((BURST_LEN > 2) ? $clog2(BURST_LEN) : 1)-1:0] m_beat,
  output logic                                          busy
);

  // Stream handshake: a beat moves when m_valid && m_ready at posedge. Once m_valid
  // rises, m_data/m_last/m_beat are held stable until that beat is accepted.

  localparam int BW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

  // S_IDLE: hold register empty; S_WAIT: word held, framing unknown;
  // S_PRES: word presented, framing latched until accepted.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PRES = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_last_lat;
  logic [BW-1:0]         r_beat;
  logic [TW-1:0]         r_to_cnt;

  logic w_at_last;
  logic w_present;
  logic w_last_now;
  logic w_valid;
  logic w_last;
  logic w_xfer;
  logic w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_present   = 1'b0;
    w_last_now  = 1'b0;
    w_at_last   = (r_beat == LAST_BEAT);

    // Framing decision for a held word, highest priority first.
    if (r_state == S_WAIT) begin
      if (w_at_last) begin
        w_present  = 1'b1;
        w_last_now = 1'b1;
      end else if (!fifo_empty) begin
        w_present  = 1'b1;
        w_last_now = 1'b0;
      end else if ((r_to_cnt == TO_MAX) || flush) begin
        w_present  = 1'b1;
        w_last_now = 1'b1;
      end
    end

    w_valid = (r_state == S_PRES) || w_present;
    w_last  = (r_state == S_PRES) ? r_last_lat : w_last_now;
    w_xfer  = w_valid && m_ready;
    w_pop   = !rst && !fifo_empty && ((r_state == S_IDLE) || w_xfer);

    // A pop in the same cycle as a transfer reloads the hold register without a bubble.
    if (w_pop) begin
      w_state_nxt = S_WAIT;
    end else if (w_xfer) begin
      w_state_nxt = S_IDLE;
    end else if (w_present) begin
      w_state_nxt = S_PRES;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold     <= '0;
      r_last_lat <= 1'b0;
      r_beat     <= '0;
      r_to_cnt   <= '0;
    end else begin
      if (w_pop) begin
        r_hold <= fifo_data;
      end
      if (w_present) begin
        r_last_lat <= w_last_now;
      end
      if (w_xfer) begin
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
      // Idle timer saturates so a long-held word keeps the timeout condition true.
      if (w_pop) begin
        r_to_cnt <= '0;
      end else if ((r_state != S_IDLE) && !w_present && (r_to_cnt != TO_MAX)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign fifo_rd_en = w_pop;
  assign m_data     = r_hold;
  assign m_valid    = w_valid;
  assign m_last     = w_last;
  assign m_beat     = r_beat;
  assign busy       = (r_state != S_IDLE);

endmodule
